ccsds_123b2_selftest_sequencer: RTL and testbench

CCSDS_123B2_SELFTEST_SEQUENCER -- requirements
Module: ccsds_123b2_selftest_sequencer

---
 rtl/ccsds_123b2_selftest_sequencer_if.sv | 44 ++++
 rtl/ccsds_123b2_selftest_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_ccsds_123b2_selftest_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ccsds_123b2_selftest_sequencer_if.sv
// Stream, core-control and pattern-ROM signals between the self-test sequencer and its
// surroundings; master is the sequencer side, slave is the environment (ext source/sink, core, ROM).
interface ccsds_123b2_selftest_sequencer_if #(
    parameter int IN_WIDTH      = 16,
    parameter int OUT_WIDTH     = 64,
    parameter int PATTERN_WORDS = 61200
);
    localparam int ADDR_W = (PATTERN_WORDS > 1) ? $clog2(PATTERN_WORDS) : 1;

    logic [IN_WIDTH-1:0]  ext_in_d;
    logic                 ext_in_valid;
    logic                 ext_in_ready;
    logic [OUT_WIDTH-1:0] ext_out_d;
    logic                 ext_out_valid;
    logic                 ext_out_last;
    logic                 ext_out_ready;
    logic [IN_WIDTH-1:0]  core_in_d;
    logic                 core_in_valid;
    logic                 core_in_ready;
    logic [OUT_WIDTH-1:0] core_out_d;
    logic                 core_out_valid;
    logic                 core_out_last;
    logic                 core_out_ready;
    logic                 core_rst_req;
    logic                 rom_en;
    logic [ADDR_W-1:0]    rom_addr;
    logic [IN_WIDTH-1:0]  rom_data;

    modport master (
        input  ext_in_d, ext_in_valid, output ext_in_ready,
        output ext_out_d, ext_out_valid, ext_out_last, input ext_out_ready,
        output core_in_d, core_in_valid, input core_in_ready,
        input  core_out_d, core_out_valid, core_out_last, output core_out_ready,
        output core_rst_req, rom_en, rom_addr, input rom_data
    );

    modport slave (
        output ext_in_d, ext_in_valid, input ext_in_ready,
        input  ext_out_d, ext_out_valid, ext_out_last, output ext_out_ready,
        input  core_in_d, core_in_valid, output core_in_ready,
        output core_out_d, core_out_valid, core_out_last, input core_out_ready,
        input  core_rst_req, rom_en, rom_addr, output rom_data
    );
endinterface

// File: rtl/ccsds_123b2_selftest_sequencer.sv
// Built-in self-test around a CCSDS 123.0-B-2 core: pass-through when idle, otherwise replays a
// ROM pattern into the core and checks output word count and checksum against references.
module ccsds_123b2_selftest_sequencer #(
    parameter int                   IN_WIDTH        = 16,
    parameter int                   OUT_WIDTH       = 64,
    parameter int                   PATTERN_WORDS   = 61200,
    parameter int                   REF_OUT_WORDS   = 4881,
    parameter logic [OUT_WIDTH-1:0] REF_CHECKSUM    = 64'h0004360006B58000,
    parameter int                   CHECKSUM_MODE   = 0,
    parameter int                   TIMEOUT_CYCLES  = 217500,
    parameter int                   CORE_RST_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic selftest_start,
    ccsds_123b2_selftest_sequencer_if.master bus,
    output logic st_busy,
    output logic st_done,
    output logic st_fail,
    output logic st_timeout,
    output logic st_cnt_err,
    output logic st_sum_err
);
    localparam int ADDR_W = (PATTERN_WORDS > 1) ? $clog2(PATTERN_WORDS) : 1;
    localparam int CNT_W  = $clog2(PATTERN_WORDS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int OCNT_W = $clog2(REF_OUT_WORDS + 2);
    localparam int RST_W  = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  PAT_END  = CNT_W'(PATTERN_WORDS);
    localparam logic [TMO_W-1:0]  TMO_END  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [OCNT_W-1:0] OUT_REF  = OCNT_W'(REF_OUT_WORDS);
    localparam logic [RST_W-1:0]  RST_LAST = RST_W'(CORE_RST_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_CORE_RST, S_RUN, S_CHECK, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [RST_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [OCNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic [OUT_WIDTH-1:0]  chk_q, chk_d;
    logic [IN_WIDTH-1:0]   fifo_mem_q [2];
    logic [IN_WIDTH-1:0]   fifo_mem_d [2];
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  timeout_q, timeout_d, fail_q, fail_d;
    logic                  cnt_err_q, cnt_err_d, sum_err_q, sum_err_d;

    logic fifo_pop, rom_rd, out_acc;

    // A read may issue as long as the slot it lands in is guaranteed free, counting this cycle's pop.
    assign fifo_pop = (state_q == S_RUN) && (occ_q != 2'd0) && bus.core_in_ready;
    assign rom_rd   = (state_q == S_RUN) && (addr_q < PAT_END)
                   && ((3'(occ_q) + 3'(inflight_q) - 3'(fifo_pop)) < 3'd2);
    assign out_acc  = (state_q == S_RUN) && bus.core_out_valid;

    assign st_busy    = (state_q == S_CORE_RST) || (state_q == S_RUN) || (state_q == S_CHECK);
    assign st_done    = (state_q == S_DONE);
    assign st_fail    = fail_q;
    assign st_timeout = timeout_q;
    assign st_cnt_err = cnt_err_q;
    assign st_sum_err = sum_err_q;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        addr_d     = addr_q;
        in_cnt_d   = in_cnt_q;
        tmo_d      = tmo_q;
        out_cnt_d  = out_cnt_q;
        chk_d      = chk_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, fifo_pop};
        inflight_d = rom_rd;
        timeout_d  = timeout_q;
        fail_d     = fail_q;
        cnt_err_d  = cnt_err_q;
        sum_err_d  = sum_err_q;

        bus.ext_in_ready   = 1'b0;
        bus.ext_out_d      = '0;
        bus.ext_out_valid  = 1'b0;
        bus.ext_out_last   = 1'b0;
        bus.core_in_d      = '0;
        bus.core_in_valid  = 1'b0;
        bus.core_out_ready = 1'b0;
        bus.core_rst_req   = 1'b0;
        bus.rom_en         = rom_rd;
        bus.rom_addr       = addr_q[ADDR_W-1:0];

        if (inflight_q) begin
            fifo_mem_d[wr_ptr_q] = bus.rom_data;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (fifo_pop) begin
            rd_ptr_d = ~rd_ptr_q;
            in_cnt_d = in_cnt_q + CNT_W'(1);
        end
        if (rom_rd) addr_d = addr_q + CNT_W'(1);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                bus.ext_in_ready   = bus.core_in_ready;
                bus.core_in_d      = bus.ext_in_d;
                bus.core_in_valid  = bus.ext_in_valid;
                bus.ext_out_d      = bus.core_out_d;
                bus.ext_out_valid  = bus.core_out_valid;
                bus.ext_out_last   = bus.core_out_last;
                bus.core_out_ready = bus.ext_out_ready;
                if (selftest_start) begin
                    state_d    = S_CORE_RST;
                    rst_cnt_d  = '0;
                    addr_d     = '0;
                    in_cnt_d   = '0;
                    tmo_d      = '0;
                    out_cnt_d  = '0;
                    chk_d      = '0;
                    wr_ptr_d   = 1'b0;
                    rd_ptr_d   = 1'b0;
                    occ_d      = 2'd0;
                    inflight_d = 1'b0;
                    timeout_d  = 1'b0;
                    fail_d     = 1'b0;
                    cnt_err_d  = 1'b0;
                    sum_err_d  = 1'b0;
                end
            end
            S_CORE_RST: begin
                bus.core_rst_req   = 1'b1;
                bus.core_out_ready = 1'b1;
                if (rst_cnt_q == RST_LAST) state_d = S_RUN;
                else                       rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            S_RUN: begin
                bus.core_out_ready = 1'b1;
                bus.core_in_valid  = (occ_q != 2'd0);
                bus.core_in_d      = fifo_mem_q[rd_ptr_q];
                tmo_d              = tmo_q + TMO_W'(1);
                if (out_acc) begin
                    if (out_cnt_q != '1) out_cnt_d = out_cnt_q + OCNT_W'(1);
                    if (CHECKSUM_MODE == 0) chk_d = chk_q + bus.core_out_d;
                    else                    chk_d = chk_q ^ bus.core_out_d;
                end
                // A final word in the same cycle as the timeout still gets its count/checksum verdict.
                if (out_acc && bus.core_out_last) begin
                    state_d = S_CHECK;
                end else if (tmo_q + TMO_W'(1) == TMO_END) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    fail_d    = 1'b1;
                end
            end
            S_CHECK: begin
                bus.core_out_ready = 1'b1;
                cnt_err_d = (out_cnt_q != OUT_REF) || (in_cnt_q != PAT_END);
                sum_err_d = (chk_q != REF_CHECKSUM);
                fail_d    = (out_cnt_q != OUT_REF) || (in_cnt_q != PAT_END)
                         || (chk_q != REF_CHECKSUM);
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: the two FIFO slots are reset too, so nothing in the block carries stale data out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_cnt_q  <= '0;
            addr_q     <= '0;
            in_cnt_q   <= '0;
            tmo_q      <= '0;
            out_cnt_q  <= '0;
            chk_q      <= '0;
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            timeout_q  <= 1'b0;
            fail_q     <= 1'b0;
            cnt_err_q  <= 1'b0;
            sum_err_q  <= 1'b0;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            addr_q     <= addr_d;
            in_cnt_q   <= in_cnt_d;
            tmo_q      <= tmo_d;
            out_cnt_q  <= out_cnt_d;
            chk_q      <= chk_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            timeout_q  <= timeout_d;
            fail_q     <= fail_d;
            cnt_err_q  <= cnt_err_d;
            sum_err_q  <= sum_err_d;
        end
    end
endmodule

// File: tb/tb_ccsds_123b2_selftest_sequencer.sv
// Directed bench: ROM and core models around the sequencer; pass, checksum error, timeout,
// mid-run reset and start-while-busy scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_ccsds_123b2_selftest_sequencer;
    localparam int          IN_W  = 16;
    localparam int          OUT_W = 64;
    localparam int          PW    = 8;
    localparam int          REF_N = 3;
    localparam logic [63:0] REF_S = 64'd6;
    localparam int          TMO   = 50;
    localparam int          RSTC  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic selftest_start = 1'b0;
    logic st_busy, st_done, st_fail, st_timeout, st_cnt_err, st_sum_err;

    ccsds_123b2_selftest_sequencer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .PATTERN_WORDS(PW)) bus ();

    ccsds_123b2_selftest_sequencer #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .PATTERN_WORDS(PW), .REF_OUT_WORDS(REF_N),
        .REF_CHECKSUM(REF_S), .CHECKSUM_MODE(0), .TIMEOUT_CYCLES(TMO), .CORE_RST_CYCLES(RSTC)
    ) dut (
        .clk(clk), .rst(rst), .selftest_start(selftest_start), .bus(bus),
        .st_busy(st_busy), .st_done(st_done), .st_fail(st_fail), .st_timeout(st_timeout),
        .st_cnt_err(st_cnt_err), .st_sum_err(st_sum_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pattern ROM: one-cycle read latency, word at address a is 0xA000 + a.
    always @(posedge clk) if (bus.rom_en === 1'b1) bus.rom_data <= 16'hA000 + 16'(bus.rom_addr);

    logic [15:0] cons [64];
    int  n_cons = 0;
    int  rom_reads = 0;
    int  last_cyc = 0;
    bit  out_acc_seen = 1'b0;

    always @(negedge clk) begin
        out_acc_seen = (bus.core_out_valid === 1'b1) && (bus.core_out_ready === 1'b1);
        if (out_acc_seen && bus.core_out_last === 1'b1) last_cyc = cyc;
        if (st_busy === 1'b1 && bus.core_in_valid === 1'b1 && bus.core_in_ready === 1'b1 && n_cons < 64) begin
            cons[n_cons] = bus.core_in_d;
            n_cons++;
        end
        if (bus.rom_en === 1'b1) rom_reads++;
    end

    bit          model_en = 1'b0;
    bit          toggle_rdy = 1'b0;
    bit          send_last = 1'b1;
    logic [63:0] emit_vals [3];
    int          emit_idx = 3;
    int          cons_base = 0;
    logic        man_rdy = 1'b0;
    logic        man_ov = 1'b0;
    logic [63:0] man_od = '0;

    // Core model: consumes PW words, then emits emit_vals back to back (last on the third if enabled).
    initial begin
        bus.core_in_ready  = 1'b0;
        bus.core_out_valid = 1'b0;
        bus.core_out_d     = '0;
        bus.core_out_last  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_acc_seen) emit_idx++;
            if (bus.core_rst_req === 1'b1) begin
                emit_idx  = 0;
                cons_base = n_cons;
            end
            if (!model_en) begin
                bus.core_in_ready  = man_rdy;
                bus.core_out_valid = man_ov;
                bus.core_out_d     = man_od;
                bus.core_out_last  = 1'b0;
            end else begin
                bus.core_in_ready = toggle_rdy ? !bus.core_in_ready : 1'b1;
                if ((n_cons - cons_base) >= PW && emit_idx < 3) begin
                    bus.core_out_valid = 1'b1;
                    bus.core_out_d     = emit_vals[emit_idx];
                    bus.core_out_last  = send_last && (emit_idx == 2);
                end else begin
                    bus.core_out_valid = 1'b0;
                    bus.core_out_d     = '0;
                    bus.core_out_last  = 1'b0;
                end
            end
        end
    end

    int run_c = 0;

    task automatic start_run(output int rst_len, output logic fail0, output logic sum0);
        int w;
        @(posedge clk); #1 selftest_start = 1'b1;
        @(posedge clk); #1 selftest_start = 1'b0;
        w = 0;
        @(negedge clk);
        while (bus.core_rst_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("core_rst_req_rise", 64'(bus.core_rst_req), 64'd1);
        fail0 = st_fail;
        sum0  = st_sum_err;
        rst_len = 0;
        while (bus.core_rst_req === 1'b1 && rst_len < 20) begin
            rst_len++;
            @(negedge clk);
        end
        run_c = cyc;
    endtask

    task automatic wait_done(output int done_c, output int extra_rst);
        int w;
        w = 0;
        extra_rst = 0;
        @(negedge clk);
        while (st_done !== 1'b1 && w < 200) begin
            if (bus.core_rst_req === 1'b1) extra_rst++;
            @(negedge clk);
            w++;
        end
        check("done_seen", 64'(st_done), 64'd1);
        done_c = cyc;
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({st_busy, st_done, st_fail, st_timeout, st_cnt_err, st_sum_err,
                    bus.core_rst_req, bus.rom_en, bus.core_in_valid, bus.ext_in_ready,
                    bus.ext_out_valid, bus.ext_out_last, bus.core_out_ready, bus.rom_addr});
    endfunction

    initial begin
        int rst_len, done_c, extra, rb, any_bad;
        logic fail0, sum0;

        bus.ext_in_d      = '0;
        bus.ext_in_valid  = 1'b0;
        bus.ext_out_ready = 1'b0;
        emit_vals[0] = 64'd1; emit_vals[1] = 64'd2; emit_vals[2] = 64'd3;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outs_vec(), 64'd0);
        check("reset_core_in_d", 64'(bus.core_in_d), 64'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Passing run with core_in_ready toggling; start pulsed mid-run must be ignored.
        model_en = 1'b1; toggle_rdy = 1'b1; send_last = 1'b1;
        rb = rom_reads;
        start_run(rst_len, fail0, sum0);
        check("t1_core_rst_len", 64'(rst_len), 64'(RSTC));
        check("t1_busy_in_run", 64'(st_busy), 64'd1);
        @(posedge clk); #1 selftest_start = 1'b1;
        @(posedge clk); #1 selftest_start = 1'b0;
        wait_done(done_c, extra);
        check("t1_start_ignored", 64'(extra), 64'd0);
        check("t1_fail", 64'(st_fail), 64'd0);
        check("t1_sum_err", 64'(st_sum_err), 64'd0);
        check("t1_cnt_err", 64'(st_cnt_err), 64'd0);
        check("t1_timeout", 64'(st_timeout), 64'd0);
        check("t1_busy_done", 64'(st_busy), 64'd0);
        check("t1_done_after_check", 64'(done_c - last_cyc), 64'd2);
        check("t1_words_consumed", 64'(n_cons - cons_base), 64'(PW));
        for (int i = 0; i < PW; i++)
            check($sformatf("t1_core_in_d[%0d]", i), 64'(cons[cons_base + i]), 64'(16'hA000 + i));
        check("t1_rom_reads", 64'(rom_reads - rb), 64'(PW));

        // Wrong checksum (1+2+4=7), correct count.
        toggle_rdy = 1'b0;
        emit_vals[2] = 64'd4;
        start_run(rst_len, fail0, sum0);
        wait_done(done_c, extra);
        check("t2_sum_err", 64'(st_sum_err), 64'd1);
        check("t2_cnt_err", 64'(st_cnt_err), 64'd0);
        check("t2_fail", 64'(st_fail), 64'd1);
        check("t2_timeout", 64'(st_timeout), 64'd0);

        // Restart from a failed DONE clears status; no last -> timeout after 50 RUN cycles.
        send_last = 1'b0;
        emit_vals[2] = 64'd3;
        start_run(rst_len, fail0, sum0);
        check("t3_fail_cleared", 64'(fail0), 64'd0);
        check("t3_sum_err_cleared", 64'(sum0), 64'd0);
        check("t3_core_rst_len", 64'(rst_len), 64'(RSTC));
        wait_done(done_c, extra);
        check("t3_run_cycles", 64'(done_c - run_c), 64'(TMO));
        check("t3_timeout", 64'(st_timeout), 64'd1);
        check("t3_fail", 64'(st_fail), 64'd1);

        // Reset in the middle of RUN aborts; afterwards the block is a pass-through.
        send_last = 1'b1;
        start_run(rst_len, fail0, sum0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        model_en = 1'b0; man_rdy = 1'b0; man_ov = 1'b0; man_od = '0;
        repeat (2) @(negedge clk);
        check("t4_outputs_in_reset", outs_vec(), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        any_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (st_done !== 1'b0 || st_busy !== 1'b0) any_bad++;
        end
        check("t4_no_done_after_abort", 64'(any_bad), 64'd0);
        check("t4_outputs_after_release", outs_vec(), 64'd0);
        check("t4_core_in_d_zero", 64'(bus.core_in_d), 64'd0);
        #2;
        bus.ext_in_d = 16'hABCD;
        bus.ext_in_valid = 1'b1;
        #1;
        check("t4_core_in_d_pass", 64'(bus.core_in_d), 64'h0000_0000_0000_ABCD);
        check("t4_core_in_valid_pass", 64'(bus.core_in_valid), 64'd1);
        man_rdy = 1'b1; man_ov = 1'b1; man_od = 64'h0123_4567_89AB_CDEF;
        bus.ext_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_ext_in_ready_pass", 64'(bus.ext_in_ready), 64'd1);
        check("t4_ext_out_valid_pass", 64'(bus.ext_out_valid), 64'd1);
        check("t4_ext_out_d_pass", bus.ext_out_d, 64'h0123_4567_89AB_CDEF);
        check("t4_core_out_ready_pass", 64'(bus.core_out_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
